// File: rtl/oled_pkg.sv
// ============================================================================
// Package     : oled_pkg
// Description : Shared types and constants for the SSD1306 power-up sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oled_pkg;

    typedef enum logic [1:0] {
        OP_PIN = 2'd0,
        OP_CMD = 2'd1,
        OP_DLY = 2'd2,
        OP_END = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DELAY    = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_REL = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] arg;
    } rom_entry_t;

    localparam int ROM_DEPTH = 18;
    localparam int PC_W      = 5;

    localparam logic [7:0] CMD_DISP_OFF      = 8'hAE;
    localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
    localparam logic [7:0] CMD_CP_ENABLE     = 8'h14;
    localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
    localparam logic [7:0] CMD_PRECHARGE_VAL = 8'hF1;
    localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
    localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
    localparam logic [7:0] CMD_COM_PINS_VAL  = 8'h20;
    localparam logic [7:0] CMD_DISP_ON       = 8'hAF;

    function automatic rom_entry_t rom_word(input op_e op, input logic [7:0] arg);
        rom_word.op  = op;
        rom_word.arg = arg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oled_init_rom.sv
// ============================================================================
// Module      : oled_init_rom
// Description : Combinational micro-op ROM for the panel power-up sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_init_rom
    import oled_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    output op_e             op_o,
    output logic [7:0]      arg_o
);

    rom_entry_t w_entry;

    // PIN arg bits: [0]=vdd_en, [1]=res_release, [2]=vbat_en
    always_comb begin
        w_entry = rom_word(OP_END, 8'h00);
        case (pc_i)
            5'd0:    w_entry = rom_word(OP_PIN, 8'b011);
            5'd1:    w_entry = rom_word(OP_DLY, 8'd1);
            5'd2:    w_entry = rom_word(OP_CMD, CMD_DISP_OFF);
            5'd3:    w_entry = rom_word(OP_PIN, 8'b001);
            5'd4:    w_entry = rom_word(OP_DLY, 8'd1);
            5'd5:    w_entry = rom_word(OP_PIN, 8'b011);
            5'd6:    w_entry = rom_word(OP_CMD, CMD_CHARGE_PUMP);
            5'd7:    w_entry = rom_word(OP_CMD, CMD_CP_ENABLE);
            5'd8:    w_entry = rom_word(OP_CMD, CMD_PRECHARGE);
            5'd9:    w_entry = rom_word(OP_CMD, CMD_PRECHARGE_VAL);
            5'd10:   w_entry = rom_word(OP_PIN, 8'b111);
            5'd11:   w_entry = rom_word(OP_DLY, 8'd100);
            5'd12:   w_entry = rom_word(OP_CMD, CMD_SEG_REMAP);
            5'd13:   w_entry = rom_word(OP_CMD, CMD_COM_SCAN_DEC);
            5'd14:   w_entry = rom_word(OP_CMD, CMD_COM_PINS);
            5'd15:   w_entry = rom_word(OP_CMD, CMD_COM_PINS_VAL);
            5'd16:   w_entry = rom_word(OP_CMD, CMD_DISP_ON);
            default: w_entry = rom_word(OP_END, 8'h00);
        endcase
    end

    assign op_o  = w_entry.op;
    assign arg_o = w_entry.arg;

endmodule

`default_nettype wire

// File: rtl/oled_init_sequencer.sv
// ============================================================================
// Module      : oled_init_sequencer
// Description : Walks the init ROM: rail/reset pins, ms delays, SPI command bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_init_sequencer
    import oled_pkg::*;
#(
    parameter int MS_CYCLES  = 100000,
    parameter int HS_TIMEOUT = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       done_send,
    output logic [7:0] spi_data,
    output logic       spi_load,
    output logic       oled_dc,
    output logic       oled_res,
    output logic       oled_vdd,
    output logic       oled_vbat,
    output logic       init_done,
    output logic       init_err
);

    localparam int MS_W     = $clog2(MS_CYCLES + 1);
    localparam int HS_W     = $clog2(HS_TIMEOUT + 1);
    localparam int LAST_CYC = (MS_CYCLES > 1) ? MS_CYCLES - 2 : 0;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ms_cnt_q, ms_cnt_d;
    logic [MS_W-1:0]   cyc_q, cyc_d;
    logic [HS_W-1:0]   hs_q, hs_d;
    logic [7:0]        data_q, data_d;
    logic              load_q, load_d;
    logic              res_q, res_d;
    logic              vdd_q, vdd_d;
    logic              vbat_q, vbat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              meta_q, done_s_q;

    op_e               w_op;
    logic [7:0]        w_arg;

    oled_init_rom u_rom (
        .pc_i  (pc_q),
        .op_o  (w_op),
        .arg_o (w_arg)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ms_cnt_q <= '0;
            cyc_q    <= '0;
            hs_q     <= '0;
            data_q   <= 8'h00;
            load_q   <= 1'b0;
            res_q    <= 1'b1;
            vdd_q    <= 1'b1;
            vbat_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            meta_q   <= 1'b0;
            done_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ms_cnt_q <= ms_cnt_d;
            cyc_q    <= cyc_d;
            hs_q     <= hs_d;
            data_q   <= data_d;
            load_q   <= load_d;
            res_q    <= res_d;
            vdd_q    <= vdd_d;
            vbat_q   <= vbat_d;
            done_q   <= done_d;
            err_q    <= err_d;
            meta_q   <= done_send;
            done_s_q <= meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ms_cnt_d = ms_cnt_q;
        cyc_d    = cyc_q;
        hs_d     = hs_q;
        data_d   = data_q;
        load_d   = load_q;
        res_d    = res_q;
        vdd_d    = vdd_q;
        vbat_d   = vbat_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            FETCH: begin
                case (w_op)
                    OP_PIN: begin
                        vdd_d  = ~w_arg[0];
                        res_d  = w_arg[1];
                        vbat_d = ~w_arg[2];
                        pc_d   = pc_q + PC_W'(1);
                    end
                    OP_CMD: begin
                        data_d  = w_arg;
                        load_d  = 1'b1;
                        hs_d    = '0;
                        state_d = WAIT_ACK;
                    end
                    OP_DLY: begin
                        ms_cnt_d = w_arg;
                        cyc_d    = '0;
                        state_d  = DELAY;
                    end
                    OP_END: begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end
            DELAY: begin
                // The DLY fetch cycle counts as the first cycle of the delay,
                // so the final millisecond ends one count early.
                if (ms_cnt_q == 8'd0 ||
                    (ms_cnt_q == 8'd1 && cyc_q == MS_W'(LAST_CYC))) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = FETCH;
                end else if (cyc_q == MS_W'(MS_CYCLES - 1)) begin
                    cyc_d    = '0;
                    ms_cnt_d = ms_cnt_q - 8'd1;
                end else begin
                    cyc_d = cyc_q + MS_W'(1);
                end
            end
            WAIT_ACK: begin
                if (done_s_q) begin
                    load_d  = 1'b0;
                    hs_d    = '0;
                    state_d = WAIT_REL;
                end else if (hs_q == HS_W'(HS_TIMEOUT - 1)) begin
                    load_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    hs_d = hs_q + HS_W'(1);
                end
            end
            WAIT_REL: begin
                if (!done_s_q) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = FETCH;
                end else if (hs_q == HS_W'(HS_TIMEOUT - 1)) begin
                    load_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    hs_d = hs_q + HS_W'(1);
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = FETCH;
        endcase
    end

    assign spi_data  = data_q;
    assign spi_load  = load_q;
    assign oled_dc   = 1'b0;
    assign oled_res  = res_q;
    assign oled_vdd  = vdd_q;
    assign oled_vbat = vbat_q;
    assign init_done = done_q;
    assign init_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_init_sequencer.sv
// ============================================================================
// Module      : tb_oled_init_sequencer
// Description : Directed bench: normal run, stray/late done_send, reset, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_t;
    logic       m_done, stray, ds_t;
    logic       ds_a;
    assign ds_a = m_done | stray;

    logic [7:0] data_a, data_t;
    logic load_a, dc_a, res_a, vdd_a, vbat_a, idone_a, ierr_a;
    logic load_t, dc_t, res_t, vdd_t, vbat_t, idone_t, ierr_t;

    oled_init_sequencer #(.MS_CYCLES(10), .HS_TIMEOUT(4096)) dut_a (
        .clock(clk), .reset(rst_a), .done_send(ds_a),
        .spi_data(data_a), .spi_load(load_a), .oled_dc(dc_a), .oled_res(res_a),
        .oled_vdd(vdd_a), .oled_vbat(vbat_a), .init_done(idone_a), .init_err(ierr_a)
    );

    oled_init_sequencer #(.MS_CYCLES(10), .HS_TIMEOUT(64)) dut_t (
        .clock(clk), .reset(rst_t), .done_send(ds_t),
        .spi_data(data_t), .spi_load(load_t), .oled_dc(dc_t), .oled_res(res_t),
        .oled_vdd(vdd_t), .oled_vbat(vbat_t), .init_done(idone_t), .init_err(ierr_t)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       vdd;
        logic       res;
        logic       vbat;
    } exp_t;
    exp_t tbl [10];

    // SPI serializer model: done_send 40 cycles after load, drop rel cycles after load falls
    int rel        = 20;
    int m_st       = 0;
    int m_cnt      = 0;
    int m_fall_cyc = 0;
    initial begin
        m_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                m_st = 0; m_cnt = 0; m_done = 1'b0;
            end else begin
                case (m_st)
                    0: if (load_a) begin
                        m_cnt++;
                        if (m_cnt >= 40) begin m_done = 1'b1; m_st = 1; end
                    end
                    1: if (!load_a) begin m_cnt = 0; m_st = 2; end
                    default: begin
                        m_cnt++;
                        if (m_cnt >= rel) begin
                            m_done = 1'b0; m_fall_cyc = cyc; m_st = 0; m_cnt = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor for the main instance
    int idx = 0;
    logic ld_prev = 1'b0, res_prev = 1'b1, vdd_prev = 1'b1, vbat_prev = 1'b1;
    logic [7:0] data_at_rise = 8'h00;
    int load_cyc [10];
    int res_fall = 0, res_rise = 0, vdd_fall = 0, vbat_fall = 0;
    always @(negedge clk) begin
        if (!rst_a) begin
            idx = 0; ld_prev = 1'b0; res_prev = 1'b1; vdd_prev = 1'b1; vbat_prev = 1'b1;
        end else begin
            if (load_a && !ld_prev) begin
                if (idx < 10) begin
                    chk("load_data", {24'h0, data_a}, {24'h0, tbl[idx].data});
                    chk("load_pins", {29'h0, vdd_a, res_a, vbat_a},
                        {29'h0, tbl[idx].vdd, tbl[idx].res, tbl[idx].vbat});
                    load_cyc[idx] = cyc;
                end else begin
                    chk("extra_load_index", idx, 9);
                end
                if (idx > 0) chk_rng("load_after_done_low", cyc - m_fall_cyc, 2, 1000000);
                data_at_rise = data_a;
                idx++;
            end
            if (!load_a && ld_prev) chk("data_stable", {24'h0, data_a}, {24'h0, data_at_rise});
            if (!res_a && res_prev) res_fall = cyc;
            if (res_a && !res_prev) res_rise = cyc;
            if (!vdd_a && vdd_prev) vdd_fall = cyc;
            if (!vbat_a && vbat_prev) vbat_fall = cyc;
            ld_prev = load_a; res_prev = res_a; vdd_prev = vdd_a; vbat_prev = vbat_a;
        end
    end

    // Monitor for the timeout instance
    int t_loads = 0, t_load_cyc = 0, t_err_cyc = 0;
    logic tld_prev = 1'b0, terr_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_t) begin
            if (load_t && !tld_prev) begin t_loads++; t_load_cyc = cyc; end
            if (ierr_t && !terr_prev) t_err_cyc = cyc;
        end
        tld_prev  = load_t;
        terr_prev = ierr_t;
    end

    initial begin
        tbl[0] = '{8'hAE, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{8'h8D, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{8'h14, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'hD9, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'hF1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{8'hA1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'hC8, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'hDA, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{8'h20, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{8'hAF, 1'b0, 1'b1, 1'b0};

        rst_a = 1'b0; rst_t = 1'b0; stray = 1'b0; ds_t = 1'b0; rel = 20;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", {24'h0, data_a}, 32'h0);
        chk("rst_load", {31'h0, load_a}, 32'h0);
        chk("rst_dc",   {31'h0, dc_a},   32'h0);
        chk("rst_res",  {31'h0, res_a},  32'h1);
        chk("rst_vdd",  {31'h0, vdd_a},  32'h1);
        chk("rst_vbat", {31'h0, vbat_a}, 32'h1);
        chk("rst_done", {31'h0, idone_a}, 32'h0);
        chk("rst_err",  {31'h0, ierr_a},  32'h0);
        rst_a = 1'b1; rst_t = 1'b1;

        // Phase 1: normal run with a stray done_send pulse inside the 100 ms delay
        for (int k = 0; k < 3000 && vbat_a !== 1'b0; k++) @(negedge clk);
        chk("p1_vbat_on", {31'h0, vbat_a}, 32'h0);
        repeat (300) @(negedge clk);
        stray = 1'b1;
        repeat (5) @(negedge clk);
        stray = 1'b0;
        for (int k = 0; k < 5000 && idone_a !== 1'b1; k++) @(negedge clk);
        chk("p1_init_done", {31'h0, idone_a}, 32'h1);
        chk("p1_init_err",  {31'h0, ierr_a},  32'h0);
        chk("p1_load_count", idx, 10);
        chk("p1_dc", {31'h0, dc_a}, 32'h0);
        chk_rng("p1_res_low_cycles", res_rise - res_fall, 9, 11);
        chk_rng("p1_vdd_before_load", load_cyc[0] - vdd_fall, 1, 100000);
        chk_rng("p1_vbat_to_A1", load_cyc[5] - vbat_fall, 1000, 1100);

        // Timeout instance: no done_send ever
        chk("t_err",   {31'h0, ierr_t},  32'h1);
        chk("t_load",  {31'h0, load_t},  32'h0);
        chk("t_done",  {31'h0, idone_t}, 32'h0);
        chk("t_loads", t_loads, 1);
        chk_rng("t_err_latency", t_err_cyc - t_load_cyc, 1, 67);
        chk("t_data_frozen", {24'h0, data_t}, 32'hAE);
        chk("t_pins_frozen", {29'h0, vdd_t, res_t, vbat_t}, 32'b011);

        // Phase 2: slow done_send release, reset pulsed mid 100 ms delay, full replay
        @(negedge clk);
        rst_a = 1'b0; rel = 200;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 5000 && vbat_a !== 1'b0; k++) @(negedge clk);
        chk("p2_vbat_on", {31'h0, vbat_a}, 32'h0);
        repeat (300) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("p2_rst_pins", {28'h0, vbat_a, vdd_a, res_a, load_a}, 32'b1110);
        chk("p2_rst_done", {31'h0, idone_a}, 32'h0);
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 8000 && idone_a !== 1'b1; k++) @(negedge clk);
        chk("p2_init_done", {31'h0, idone_a}, 32'h1);
        chk("p2_init_err",  {31'h0, ierr_a},  32'h0);
        chk("p2_load_count", idx, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
